// File: rtl/vend_ctrl_if.sv
// rtl/vend_ctrl_if.sv - vending controller coin/product/dispense signal bundle
// master drives coins, prices and requests; slave is the controller.
interface vend_ctrl_if #(
  parameter int N_PROD = 4,
  parameter int CW     = 8
);
  localparam int SW = $clog2(N_PROD);

  logic [1:0]           coin;
  logic [N_PROD*CW-1:0] price;
  logic                 buy;
  logic [SW-1:0]        buy_sel;
  logic                 cancel;
  logic [CW-1:0]        credit;
  logic [N_PROD-1:0]    listo;
  logic                 vend_vld;
  logic [SW-1:0]        vend_id;
  logic                 chg_pulse;
  logic                 coin_rej;
  logic                 buy_nack;
  logic                 busy;

  modport master (
    output coin, price, buy, buy_sel, cancel,
    input  credit, listo, vend_vld, vend_id, chg_pulse, coin_rej, buy_nack, busy
  );

  modport slave (
    input  coin, price, buy, buy_sel, cancel,
    output credit, listo, vend_vld, vend_id, chg_pulse, coin_rej, buy_nack, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending controller: credit accumulation, vend, change payout
// Optional idle-credit auto refund enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int N_PROD      = 4,
  parameter int CW          = 8,
  parameter int COIN1       = 2,
  parameter int COIN2       = 3,
  parameter int COIN3       = 4,
  parameter int MAX_CREDIT  = 2**CW - 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic        clk,
  input logic        reset,
  vend_ctrl_if.slave bus
);
  localparam int SW = $clog2(N_PROD);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] vend_id_q, vend_id_d;
  logic          vend_vld_q, vend_vld_d;
  logic          chg_q, chg_d;
  logic          coin_rej_q, coin_rej_d;
  logic          nack_q, nack_d;
  logic          busy_q;

  logic [CW-1:0] coin_val;
  logic [CW:0]   coin_sum;
  logic [CW-1:0] price_sel;
  logic          in_idle, coin_nz, coin_over, sel_ok;
  logic          cancel_acc, buy_acc, coin_acc;
  logic          timeout_fire;

  always_comb begin
    coin_val = '0;
    case (bus.coin)
      2'b01:   coin_val = CW'(COIN1);
      2'b10:   coin_val = CW'(COIN2);
      2'b11:   coin_val = CW'(COIN3);
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < N_PROD; i++)
      if (SW'(i) == bus.buy_sel) price_sel = bus.price[i*CW +: CW];
  end

  // Sum is one bit wider so an overflowing coin is rejected instead of wrapping
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_over = coin_sum > (CW+1)'(MAX_CREDIT);
  assign coin_nz   = bus.coin != 2'b00;
  assign sel_ok    = {1'b0, bus.buy_sel} < (SW+1)'(N_PROD);
  assign in_idle   = state_q == IDLE;

  assign cancel_acc = in_idle && bus.cancel && credit_q != '0;
  assign buy_acc    = in_idle && !cancel_acc && bus.buy && sel_ok && credit_q >= price_sel;
  assign coin_acc   = in_idle && coin_nz && !cancel_acc && !buy_acc && !coin_over;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          idle_cnt_en;

  assign idle_cnt_en  = in_idle && credit_q != '0 && !coin_acc && !buy_acc && !cancel_acc;
  assign timeout_fire = idle_cnt_en && idle_cnt == TW'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            idle_cnt <= '0;
    else if (!idle_cnt_en || timeout_fire) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    vend_id_d  = vend_id_q;
    vend_vld_d = 1'b0;
    chg_d      = 1'b0;
    coin_rej_d = coin_nz && !coin_acc;
    nack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel_acc || timeout_fire) begin
          state_d = CHANGE;
          chg_d   = 1'b1;
        end else if (buy_acc) begin
          state_d    = VEND;
          credit_d   = credit_q - price_sel;
          vend_id_d  = bus.buy_sel;
          vend_vld_d = 1'b1;
        end else begin
          nack_d = bus.buy;
          if (coin_acc) credit_d = coin_sum[CW-1:0];
        end
      end
      VEND: begin
        if (credit_q != '0) begin
          state_d = CHANGE;
          chg_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        // Pulses are registered, so chg_d looks ahead to the credit left after this edge
        credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
        if (credit_q <= CW'(1)) state_d = IDLE;
        else                    chg_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      vend_id_q  <= '0;
      vend_vld_q <= 1'b0;
      chg_q      <= 1'b0;
      coin_rej_q <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_id_q  <= vend_id_d;
      vend_vld_q <= vend_vld_d;
      chg_q      <= chg_d;
      coin_rej_q <= coin_rej_d;
      nack_q     <= nack_d;
      busy_q     <= state_d != IDLE;
    end
  end

  for (genvar g = 0; g < N_PROD; g++) begin : g_listo
    assign bus.listo[g] = in_idle && credit_q != '0 && credit_q >= bus.price[g*CW +: CW];
  end

  assign bus.credit    = credit_q;
  assign bus.vend_vld  = vend_vld_q;
  assign bus.vend_id   = vend_id_q;
  assign bus.chg_pulse = chg_q;
  assign bus.coin_rej  = coin_rej_q;
  assign bus.buy_nack  = nack_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed self-checking bench for vend_ctrl
// Timeout steps run only when VEND_TIMEOUT_EN is defined.
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vend_ctrl_if #(.N_PROD(4), .CW(8)) bus ();

  vend_ctrl #(
    .N_PROD(4), .CW(8), .COIN1(2), .COIN2(3), .COIN3(4),
    .MAX_CREDIT(10), .TIMEOUT_CYC(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag, input int exp_n);
    int n = 0;
    int b = 0;
    int v = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      if (bus.chg_pulse) n++;
      if (bus.vend_vld) v++;
      b++;
      cyc();
    end
    chk({tag, "_pulses"}, n, exp_n);
    chk({tag, "_busy_cycles"}, b, exp_n);
    chk({tag, "_no_vend"}, v, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_credit0"}, bus.credit, 0);
  endtask

  initial begin
    bus.coin    = 2'b00;
    bus.buy     = 1'b0;
    bus.buy_sel = '0;
    bus.cancel  = 1'b0;
    bus.price   = {8'd9, 8'd5, 8'd4, 8'd2};
    cyc();
    cyc();
    chk("rst_credit", bus.credit, 0);
    chk("rst_listo", bus.listo, 0);
    chk("rst_vend_vld", bus.vend_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_chg", bus.chg_pulse, 0);
    reset = 1'b0;
    cyc();

    // Coin 01 then 10, buy product 1 (price 4)
    bus.coin = 2'b01; cyc();
    chk("c1_credit", bus.credit, 2);
    chk("c1_listo", bus.listo, 4'b0001);
    bus.coin = 2'b10; cyc();
    chk("c2_credit", bus.credit, 5);
    chk("c2_listo", bus.listo, 4'b0111);
    bus.coin = 2'b00; bus.buy = 1'b1; bus.buy_sel = 2'd1; cyc();
    bus.buy = 1'b0;
    chk("vend_vld", bus.vend_vld, 1);
    chk("vend_id", bus.vend_id, 1);
    chk("vend_credit", bus.credit, 1);
    chk("vend_busy", bus.busy, 1);
    chk("vend_listo", bus.listo, 0);
    bus.coin = 2'b01; cyc();
    bus.coin = 2'b00;
    chk("chg_pulse", bus.chg_pulse, 1);
    chk("chg_vend_done", bus.vend_vld, 0);
    chk("coin_in_vend_rej", bus.coin_rej, 1);
    chk("coin_in_vend_credit", bus.credit, 1);
    bus.buy = 1'b1; bus.buy_sel = 2'd0; cyc();
    bus.buy = 1'b0;
    chk("buy_in_chg_nonack", bus.buy_nack, 0);
    chk("after_chg_credit", bus.credit, 0);
    chk("after_chg_busy", bus.busy, 0);
    chk("after_chg_pulse", bus.chg_pulse, 0);

    // Refused buy does not block a coin in the same cycle
    bus.coin = 2'b01; cyc();
    bus.coin = 2'b01; cyc();
    bus.coin = 2'b00;
    chk("c3_credit", bus.credit, 4);
    bus.coin = 2'b00; bus.buy = 1'b0; cyc();
    bus.cancel = 1'b1; cyc();
    bus.cancel = 1'b0;
    drain("cancel4", 4);
    bus.coin = 2'b10; cyc();
    chk("credit3", bus.credit, 3);
    bus.coin = 2'b11; bus.buy = 1'b1; bus.buy_sel = 2'd2; cyc();
    bus.coin = 2'b00; bus.buy = 1'b0;
    chk("nack_pulse", bus.buy_nack, 1);
    chk("nack_coin_credit", bus.credit, 7);
    chk("nack_no_rej", bus.coin_rej, 0);
    chk("nack_busy", bus.busy, 0);
    cyc();
    chk("nack_one_cycle", bus.buy_nack, 0);
    bus.cancel = 1'b1; cyc();
    bus.cancel = 1'b0;
    drain("cancel7", 7);

    // Credit ceiling 10
    bus.coin = 2'b11; cyc();
    bus.coin = 2'b11; cyc();
    bus.coin = 2'b10; cyc();
    chk("ovf_rej", bus.coin_rej, 1);
    chk("ovf_credit", bus.credit, 8);
    bus.coin = 2'b01; cyc();
    chk("max_no_rej", bus.coin_rej, 0);
    chk("max_credit", bus.credit, 10);
    cyc();
    chk("max_over_rej", bus.coin_rej, 1);
    chk("max_over_credit", bus.credit, 10);
    bus.coin = 2'b00; bus.cancel = 1'b1; cyc();
    bus.cancel = 1'b0;
    drain("cancel10", 10);

    // Cancel beats buy
    bus.coin = 2'b11; cyc();
    bus.coin = 2'b01; cyc();
    bus.coin = 2'b00;
    chk("credit6", bus.credit, 6);
    bus.cancel = 1'b1; bus.buy = 1'b1; bus.buy_sel = 2'd0; cyc();
    bus.cancel = 1'b0; bus.buy = 1'b0;
    drain("cancel_buy6", 6);

    // Reset during the second change pulse of a 5-unit refund
    bus.coin = 2'b10; cyc();
    bus.coin = 2'b01; cyc();
    bus.coin = 2'b00;
    chk("credit5", bus.credit, 5);
    bus.cancel = 1'b1; cyc();
    bus.cancel = 1'b0;
    cyc();
    chk("rst2_second_pulse", bus.chg_pulse, 1);
    chk("rst2_credit_before", bus.credit, 4);
    reset = 1'b1;
    #1;
    chk("rst2_credit", bus.credit, 0);
    chk("rst2_chg", bus.chg_pulse, 0);
    chk("rst2_busy", bus.busy, 0);
    chk("rst2_listo", bus.listo, 0);
    chk("rst2_vend_id", bus.vend_id, 0);
    cyc();
    reset = 1'b0;
    begin
      int extra = 0;
      for (int i = 0; i < 6; i++) begin
        cyc();
        if (bus.chg_pulse || bus.busy) extra++;
      end
      chk("rst2_no_more_pulses", extra, 0);
      chk("rst2_credit_lost", bus.credit, 0);
    end

`ifdef VEND_TIMEOUT_EN
    bus.coin = 2'b11; cyc();
    bus.coin = 2'b00;
    repeat (7) cyc();
    chk("to_not_yet", bus.busy, 0);
    cyc();
    chk("to_fire", bus.chg_pulse, 1);
    drain("to4", 4);
    bus.coin = 2'b11; cyc();
    bus.coin = 2'b00;
    repeat (6) cyc();
    bus.coin = 2'b01; cyc();
    bus.coin = 2'b00;
    chk("to_restart_credit", bus.credit, 6);
    repeat (7) cyc();
    chk("to_restart_hold", bus.busy, 0);
    cyc();
    chk("to_restart_fire", bus.chg_pulse, 1);
    drain("to6", 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL have parameter N_PROD, default 4, giving the number of products (2..16).
REQ-002 The block SHALL have parameter CW, default 8, giving the credit width in bits.
REQ-003 The block SHALL have parameters COIN1/COIN2/COIN3, defaults 2/3/4, giving the credit value of coin codes 01/10/11.
REQ-004 The block SHALL have parameter MAX_CREDIT, default 2**CW-1, giving the credit ceiling.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 1000, giving the idle-credit timeout in cycles (used only under REQ-030).
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 coin  input  2  coin code; 00 = none, 01/10/11 = COIN1/COIN2/COIN3.
REQ-009 price  input  N_PROD*CW  packed per-product prices; product i occupies bits [i*CW +: CW].
REQ-010 buy  input  1  purchase request, one cycle.
REQ-011 buy_sel  input  $clog2(N_PROD)  product index for buy.
REQ-012 cancel  input  1  refund request, one cycle.
REQ-013 credit  output  CW  current credit.
REQ-014 listo  output  N_PROD  bit i high when state is IDLE and credit >= price[i] and credit != 0.
REQ-015 vend_vld  output  1  one-cycle dispense strobe.
REQ-016 vend_id  output  $clog2(N_PROD)  product dispensed; valid with vend_vld.
REQ-017 chg_pulse  output  1  one credit unit returned per high cycle.
REQ-018 coin_rej  output  1  one-cycle pulse: coin not credited.
REQ-019 buy_nack  output  1  one-cycle pulse: buy refused.
REQ-020 busy  output  1  high in VEND or CHANGE.

Function
REQ-021 The state machine SHALL have states IDLE, VEND and CHANGE; vend_vld, vend_id, chg_pulse, coin_rej, buy_nack and busy SHALL be registered.
REQ-022 In IDLE, priority SHALL be cancel > buy > coin.
- cancel with credit > 0 -> CHANGE.
- cancel with credit = 0 -> no effect.
REQ-023 In IDLE, buy with buy_sel < N_PROD and credit >= price[buy_sel] SHALL, on the same edge:
- latch vend_id;
- set credit to credit - price;
- enter VEND.
REQ-024 In IDLE, a buy with buy_sel >= N_PROD or credit < price SHALL pulse buy_nack for one cycle and leave credit and state unchanged.
REQ-025 A coin SHALL be credited only in IDLE, and only with no cancel or accepted buy in the same cycle; a nacked buy does not block the coin.
- If credit + value > MAX_CREDIT, the coin SHALL be rejected (coin_rej pulse) and credit SHALL be unchanged; no wrap-around.
- Any nonzero coin in VEND or CHANGE, or blocked by cancel or an accepted buy, SHALL pulse coin_rej.
REQ-026 VEND SHALL last exactly one cycle with vend_vld = 1; the buy at edge t gives vend_vld high during cycle t+1.
- VEND -> CHANGE if credit > 0; VEND -> IDLE otherwise.
REQ-027 CHANGE SHALL decrement credit by 1 per cycle with chg_pulse = 1.
- The number of chg_pulse cycles SHALL equal the credit on CHANGE entry.
- CHANGE -> IDLE on the edge where credit reaches 0.
REQ-028 buy and cancel in VEND or CHANGE SHALL be ignored (no nack).

Reset
REQ-029 Reset SHALL immediately force:
- state = IDLE;
- credit = 0, listo = 0, vend_vld = 0, vend_id = 0, chg_pulse = 0, coin_rej = 0, buy_nack = 0, busy = 0.
Reset mid-VEND or mid-CHANGE SHALL abandon the operation with no further pulses, and the remaining credit SHALL be lost.

Configuration
REQ-030 With macro VEND_TIMEOUT_EN defined:
- an idle counter SHALL count cycles in IDLE with credit > 0 and no accepted coin, buy or cancel;
- any of those events SHALL clear the counter;
- on reaching TIMEOUT_CYC, the block SHALL enter CHANGE exactly as for cancel.
Without VEND_TIMEOUT_EN, no counter logic SHALL exist and credit SHALL be held indefinitely.

Verification
REQ-031 coin=01,10 -> credit 2 then 5; with price[1]=4, buy sel=1 -> vend_vld with vend_id=1 next cycle, then exactly 1 chg_pulse, then IDLE with credit 0.
REQ-032 credit 3 with price[2]=5, buy sel=2 -> buy_nack for one cycle, credit stays 3; coin=11 in the same cycle -> credit 7.
REQ-033 MAX_CREDIT=10, credit 8, coin=10 -> coin_rej, credit stays 8; then coin=01 -> credit 10.
REQ-034 credit 6, cancel and buy together -> 6 consecutive chg_pulse cycles, no vend_vld, busy high for 6 cycles.
REQ-035 Reset asserted on the 2nd chg_pulse cycle of a 5-unit refund -> all outputs 0 at once, no further chg_pulse after release.
REQ-036 With VEND_TIMEOUT_EN and TIMEOUT_CYC=8: credit 4 and no activity -> CHANGE after 8 cycles, then 4 chg_pulse cycles; a coin at cycle 7 restarts the count.
